// File: rtl/spram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: FSM state encoding and statistics counter width.
package spram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } arb_state_t;

  localparam int STATS_CNT_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set bit of valid, searching upward from ptr and
// wrapping at N-1 -> 0. Returns a one-hot grant, its index and a found flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && valid[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin sharing of one single-port RAM among NUM_REQ requesters, with a per-requester read
// response channel. Optional per-requester grant counters are built when SPRAM_ARB_STATS_EN is defined.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int NUM_REQ    = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  input  logic [NUM_REQ-1:0]                   rsp_ready,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 rsp_err,
  output logic                                 ram_ce,
  output logic                                 ram_we,
  output logic [ADDR_WIDTH-1:0]                ram_addr,
  output logic [DATA_WIDTH-1:0]                ram_wdata,
  input  logic [DATA_WIDTH-1:0]                ram_rdata,
`ifdef SPRAM_ARB_STATS_EN
  input  logic                                 stats_clr,
  output logic [NUM_REQ-1:0][STATS_CNT_W-1:0]  grant_cnt,
`endif
  output arb_state_t                           dbg_state,
  output logic [$clog2(NUM_REQ)-1:0]           dbg_rr_ptr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  // Handshakes: a request transfers on req_valid[i] & req_ready[i]; a response transfers on
  // rsp_valid[owner] & rsp_ready[owner]. Valid never waits on ready; ready may depend on valid.

  arb_state_t      state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n;
  logic            err_r, err_n;

  logic [NUM_REQ-1:0]    pick;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  rsp_hs, can_grant, grant, win_we, in_range;
  logic [ADDR_WIDTH-1:0] win_addr;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .gnt   (pick),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    err_n    = err_r;
    rr_ptr_n = rr_ptr;

    rsp_hs    = (state == RSP) && rsp_ready[owner];
    // Gating with reset keeps every output at zero while reset is held.
    can_grant = reset && ((state == IDLE) || rsp_hs);
    grant     = can_grant && pick_any;
    win_we    = req_we[pick_idx];
    win_addr  = req_addr[pick_idx];
    in_range  = {1'b0, win_addr} < DEPTH_LIM;

    req_ready = can_grant ? pick : '0;
    ram_ce    = grant && in_range;
    ram_we    = ram_ce && win_we;
    ram_addr  = ram_ce ? win_addr : '0;
    ram_wdata = ram_we ? req_wdata[pick_idx] : '0;

    rsp_valid = '0;
    if (state == RSP) rsp_valid[owner] = 1'b1;
    rsp_err  = (state == RSP) && err_r;
    rsp_data = ((state == RSP) && !err_r) ? ram_rdata : '0;

    if (grant) begin
      rr_ptr_n = (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
      if (win_we) begin
        state_n = IDLE;
      end else begin
        state_n = RSP;
        owner_n = pick_idx;
        err_n   = !in_range;
      end
    end else if (rsp_hs) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      owner  <= '0;
      err_r  <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      err_r  <= err_n;
      rr_ptr <= rr_ptr_n;
    end
  end

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

`ifdef SPRAM_ARB_STATS_EN
  // Counts every granted transfer, including dropped out-of-range writes; clear wins over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (grant_cnt[i] != {STATS_CNT_W{1'b1}}))
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: reset checks, a directed vector table, randomized traffic against a
// behavioural model, and a reset-during-response sequence. Honours SPRAM_ARB_STATS_EN.
module tb_spram_arbiter;
  import spram_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NR-1:0] req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_wdata;
  logic [DW-1:0] rsp_data, ram_wdata, ram_rdata;
  logic rsp_err, ram_ce, ram_we;
  logic [AW-1:0] ram_addr;
  arb_state_t dbg_state;
  logic [1:0] dbg_rr_ptr;
`ifdef SPRAM_ARB_STATS_EN
  logic stats_clr = 1'b0;
  logic [NR-1:0][31:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
`ifdef SPRAM_ARB_STATS_EN
    .stats_clr  (stats_clr),
    .grant_cnt  (grant_cnt),
`endif
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // Single-port RAM with registered read data.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr[5:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[5:0]];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: memory image, pointer, outstanding response, grant counts.
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_ptr;
  bit            m_pend;
  int            m_owner;
  logic [DW-1:0] m_data;
  bit            m_err;
  logic [31:0]   m_cnt [NR];

  task automatic model_reset();
    m_ptr = 0; m_pend = 0; m_owner = 0; m_data = '0; m_err = 0;
    for (int i = 0; i < NR; i++) m_cnt[i] = '0;
  endtask

  // Called at the negedge: checks current outputs, then advances the model across the next edge.
  task automatic model_step();
    int w;
    bit free, inr;
    logic [NR-1:0] e_ready, e_rv;
    w = -1;
    inr = 0;
    free = !m_pend || rsp_ready[m_owner];
    if (free) begin
      for (int k = 0; k < NR; k++) begin
        int j = (m_ptr + k) % NR;
        if (w < 0 && req_valid[j]) w = j;
      end
    end
    e_ready = '0;
    if (w >= 0) begin
      e_ready[w] = 1'b1;
      inr = (req_addr[w] < DEPTH);
    end
    e_rv = '0;
    if (m_pend) e_rv[m_owner] = 1'b1;

    chk("req_ready", req_ready, e_ready);
    chk("ram_ce", ram_ce, (w >= 0) && inr);
    chk("ram_we", ram_we, (w >= 0) && inr && req_we[w]);
    if (w >= 0 && inr) chk("ram_addr", ram_addr, req_addr[w]);
    if (w >= 0 && inr && req_we[w]) chk("ram_wdata", ram_wdata, req_wdata[w]);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_data", rsp_data, (m_pend && !m_err) ? m_data : '0);
    chk("rsp_err", rsp_err, m_pend && m_err);
    chk("rr_ptr", dbg_rr_ptr, m_ptr);

    if (m_pend && rsp_ready[m_owner]) m_pend = 0;
    if (w >= 0) begin
      m_ptr = (w + 1) % NR;
      if (req_we[w]) begin
        if (inr) ref_mem[req_addr[w]] = req_wdata[w];
      end else begin
        m_pend = 1; m_owner = w; m_err = !inr;
        m_data = inr ? ref_mem[req_addr[w]] : '0;
      end
    end
`ifdef SPRAM_ARB_STATS_EN
    if (stats_clr) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = '0;
    end else if (w >= 0 && m_cnt[w] != 32'hFFFF_FFFF) begin
      m_cnt[w] = m_cnt[w] + 1;
    end
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic [3:0] v, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] rrdy);
    req_valid = v;
    req_we = we;
    rsp_ready = rrdy;
    for (int i = 0; i < NR; i++) begin
      req_addr[i] = addr;
      req_wdata[i] = wdata;
    end
  endtask

`ifdef SPRAM_ARB_STATS_EN
  task automatic check_cnt(input string tag);
    for (int i = 0; i < NR; i++) chk(tag, grant_cnt[i], m_cnt[i]);
  endtask
`endif

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rrdy;
    logic [3:0]  e_ready;
    logic        e_ce;
    logic        e_we;
    logic [3:0]  e_rv;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // fairness: all four write continuously
    tbl.push_back('{4'hF, 4'hF, 32'd10, 32'h100, 4'h0, 4'h1, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0});
    tbl.push_back('{4'hF, 4'hF, 32'd10, 32'h100, 4'h0, 4'h2, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0});
    tbl.push_back('{4'hF, 4'hF, 32'd10, 32'h100, 4'h0, 4'h4, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0});
    tbl.push_back('{4'hF, 4'hF, 32'd10, 32'h100, 4'h0, 4'h8, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0});
    tbl.push_back('{4'hF, 4'hF, 32'd10, 32'h100, 4'h0, 4'h1, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0});
    // read-back of address 5
    tbl.push_back('{4'h2, 4'h2, 32'd5, 32'hDEADBEEF, 4'h0, 4'h2, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0});
    tbl.push_back('{4'h4, 4'h0, 32'd5, 32'h0, 4'h0, 4'h4, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0});
    // backpressure for three cycles with another read waiting
    tbl.push_back('{4'h1, 4'h0, 32'd10, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{4'h1, 4'h0, 32'd10, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{4'h1, 4'h0, 32'd10, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{4'h1, 4'h0, 32'd10, 32'h0, 4'h4, 4'h1, 1'b1, 1'b0, 4'h4, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{4'h0, 4'h0, 32'd0, 32'h0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 32'h100, 1'b0});
    // out of range write then read
    tbl.push_back('{4'h2, 4'h2, 32'd64, 32'h55, 4'h0, 4'h2, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0});
    tbl.push_back('{4'h4, 4'h0, 32'd64, 32'h0, 4'h0, 4'h4, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0});
    tbl.push_back('{4'h0, 4'h0, 32'd0, 32'h0, 4'h4, 4'h0, 1'b0, 1'b0, 4'h4, 32'h0, 1'b1});
    tbl.push_back('{4'h0, 4'h0, 32'd0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0});

    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();

    // reset held with every requester asking
    reset = 1'b0;
    drive_all(4'hF, 4'h5, 32'd3, 32'h1234, 4'hF);
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 4'h0);
    chk("reset_ram_ce", ram_ce, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 4'h0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_rr_ptr", dbg_rr_ptr, 2'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // directed table
    foreach (tbl[n]) begin
      drive_all(tbl[n].v, tbl[n].we, tbl[n].addr, tbl[n].wdata, tbl[n].rrdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", n), req_ready, tbl[n].e_ready);
      chk($sformatf("tbl%0d_ce", n), ram_ce, tbl[n].e_ce);
      chk($sformatf("tbl%0d_we", n), ram_we, tbl[n].e_we);
      chk($sformatf("tbl%0d_rsp_valid", n), rsp_valid, tbl[n].e_rv);
      chk($sformatf("tbl%0d_rsp_data", n), rsp_data, tbl[n].e_data);
      chk($sformatf("tbl%0d_rsp_err", n), rsp_err, tbl[n].e_err);
      model_step();
      @(posedge clk);
      #1;
    end

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_we = 4'($urandom_range(0, 15));
      rsp_ready = 4'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) begin
        req_addr[i] = $urandom_range(0, 71);
        req_wdata[i] = $urandom;
      end
      cycle();
    end

`ifdef SPRAM_ARB_STATS_EN
    drive_all(4'h0, 4'h0, 32'd0, 32'h0, 4'hF);
    cycle();
    check_cnt("grant_cnt");
    // clear with a same-cycle grant: clear wins
    stats_clr = 1'b1;
    drive_all(4'h1, 4'h1, 32'd1, 32'h77, 4'hF);
    cycle();
    stats_clr = 1'b0;
    drive_all(4'h0, 4'h0, 32'd0, 32'h0, 4'hF);
    check_cnt("grant_cnt_clr");
`endif

    // reset while a read response is pending
    drive_all(4'h0, 4'h0, 32'd0, 32'h0, 4'hF);
    cycle();
    drive_all(4'h8, 4'h0, 32'd7, 32'h0, 4'h0);
    cycle();
    req_valid = 4'h0;
    #2;
    chk("rsp6_pending", rsp_valid, 4'h8);
    reset = 1'b0;
    #1;
    chk("rsp6_rsp_valid", rsp_valid, 4'h0);
    chk("rsp6_state", dbg_state, IDLE);
    chk("rsp6_rr_ptr", dbg_rr_ptr, 2'd0);
    chk("rsp6_ram_ce", ram_ce, 1'b0);
`ifdef SPRAM_ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk("rsp6_grant_cnt", grant_cnt[i], 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive_all(4'hF, 4'hF, 32'd3, 32'hA5A5, 4'hF);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
